// File: rtl/nand4_vector_sequencer_pkg.sv
// Shared types and helpers for the NAND4 self-test sequencer and its checker.
// Holds the state encoding, vector range constants and the reference function.
package nand4_vector_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam int         VEC_COUNT = 16;
  localparam logic [3:0] LAST_VEC  = 4'hF;
  localparam int         ERR_W     = $clog2(VEC_COUNT + 1);

  localparam int MASK_E = 0;
  localparam int MASK_F = 1;
  localparam int MASK_G = 2;

  function automatic logic nand4_exp(input logic [3:0] vec);
    return ~&vec;
  endfunction

endpackage

// File: rtl/nand4_vector_sequencer_checker.sv
// Combinational comparison of the three gate outputs against the NAND4 reference.
// Bit order of mismatch follows the MASK_* indices in the package.
module nand4_checker
  import nand4_vector_sequencer_pkg::*;
(
  input  logic [3:0] vec,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  output logic [2:0] mismatch
);

  logic exp_val;

  assign exp_val          = nand4_exp(vec);
  assign mismatch[MASK_E] = e ^ exp_val;
  assign mismatch[MASK_F] = f ^ exp_val;
  assign mismatch[MASK_G] = g ^ exp_val;

endmodule

// File: rtl/nand4_vector_sequencer.sv
// Walks all 16 NAND4 input vectors, samples e/f/g on the last dwell cycle of each,
// and accumulates a failure count, first failing vector and a sticky mismatch mask.
module nand4_vector_sequencer
  import nand4_vector_sequencer_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  input  logic             e,
  input  logic             f,
  input  logic             g,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_vld,
  output logic [3:0]       fail_vec,
  output logic [2:0]       fail_mask
);

  state_t     state;
  logic [3:0] vec;
  logic [CW-1:0] cnt;
  logic [2:0] mismatch;
  logic       sample;
  logic       any_mis;

  // vec is a flop and is forced to zero outside RUN, so the gate drive is registered.
  assign {a, b, c, d} = vec;

  assign sample  = (cnt == CW'(DWELL - 1));
  assign any_mis = |mismatch;

  nand4_checker u_checker (
    .vec      (vec),
    .e        (e),
    .f        (f),
    .g        (g),
    .mismatch (mismatch)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      vec       <= 4'h0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      fail_vld  <= 1'b0;
      fail_vec  <= 4'h0;
      fail_mask <= 3'b000;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          vec <= 4'h0;
          if (start && !abort) begin
            err_cnt   <= '0;
            fail_vld  <= 1'b0;
            fail_vec  <= 4'h0;
            fail_mask <= 3'b000;
            pass      <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            // Partial results stay visible for post-mortem.
            state <= ST_IDLE;
            vec   <= 4'h0;
            busy  <= 1'b0;
            pass  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
            if (sample) begin
              if (any_mis) begin
                err_cnt   <= err_cnt + ERR_W'(1);
                fail_mask <= fail_mask | mismatch;
                if (!fail_vld) begin
                  fail_vld <= 1'b1;
                  fail_vec <= vec;
                end
              end
              if (vec == LAST_VEC) begin
                // Pass must include the vector-15 comparison made this same cycle.
                state <= ST_FIN;
                vec   <= 4'h0;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= (err_cnt == '0) && !any_mis;
              end else begin
                vec <= vec + 4'h1;
                cnt <= '0;
              end
            end
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
          vec   <= 4'h0;
          if (abort) pass <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          vec   <= 4'h0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nand4_vector_sequencer.sv
// Bench for the NAND4 sequencer: table of fault modes with scoreboarded results,
// plus hand-written reset, abort, handshake and DWELL=1 sequences.
module tb_nand4_vector_sequencer;

  logic clk = 1'b0;
  logic rst_n, start, abort;
  logic a, b, c, d, e, f, g;
  logic busy, done, pass, fail_vld;
  logic [4:0] err_cnt;
  logic [3:0] fail_vec;
  logic [2:0] fail_mask;
  logic [2:0] fault;
  logic       ref0;

  logic start1, abort1;
  logic a1, b1, c1, d1, e1, f1, g1;
  logic busy1, done1, pass1, fail_vld1;
  logic [4:0] err_cnt1;
  logic [3:0] fail_vec1;
  logic [2:0] fail_mask1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Gate under test model with injectable faults: 1=f stuck-1, 2=e inverted & g stuck-0,
  // 3=g stuck-1, 4=e stuck-0.
  always_comb begin
    ref0 = ~(a & b & c & d);
    e = ref0;
    f = ref0;
    g = ref0;
    case (fault)
      3'd1: f = 1'b1;
      3'd2: begin e = ~ref0; g = 1'b0; end
      3'd3: g = 1'b1;
      3'd4: e = 1'b0;
      default: ;
    endcase
  end

  assign e1 = ~(a1 & b1 & c1 & d1);
  assign f1 = e1;
  assign g1 = e1;

  nand4_vector_sequencer #(.DWELL(4), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_vld(fail_vld), .fail_vec(fail_vec), .fail_mask(fail_mask)
  );

  nand4_vector_sequencer #(.DWELL(1), .CW(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err_cnt1),
    .fail_vld(fail_vld1), .fail_vec(fail_vec1), .fail_mask(fail_mask1)
  );

  typedef struct {
    logic [2:0] fault;
    int         err;
    logic [3:0] fvec;
    logic [2:0] fmask;
    logic       fvld;
    logic       pass;
  } vec_t;

  vec_t tbl[5];
  vec_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One DWELL=4 run; checks drive timing each cycle and pops the scoreboard at FIN.
  task automatic run4(input int mid_start);
    vec_t x;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 64; k++) begin
      start = (k == mid_start);
      chk("busy_run", busy, 1);
      chk("drive", {a, b, c, d}, k / 4);
      chk("done_early", done, 0);
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_fin", busy, 0);
    chk("drive_fin", {a, b, c, d}, 0);
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      x = sb.pop_front();
      chk("err_cnt", err_cnt, x.err);
      chk("fail_vld", fail_vld, x.fvld);
      chk("fail_vec", fail_vec, x.fvec);
      chk("fail_mask", fail_mask, x.fmask);
      chk("pass", pass, x.pass);
      @(negedge clk);
      chk("done_once", done, 0);
      chk("pass_hold", pass, x.pass);
      $display("run fault=%0d err_cnt=%0d fail_vec=%h fail_mask=%b pass=%0d",
               x.fault, err_cnt, fail_vec, fail_mask, pass);
    end
  endtask

  initial begin
    bit seen;
    tbl[0] = '{3'd0, 0,  4'h0, 3'b000, 1'b0, 1'b1};
    tbl[1] = '{3'd1, 1,  4'hF, 3'b010, 1'b1, 1'b0};
    tbl[2] = '{3'd2, 16, 4'h0, 3'b101, 1'b1, 1'b0};
    tbl[3] = '{3'd3, 1,  4'hF, 3'b100, 1'b1, 1'b0};
    tbl[4] = '{3'd4, 15, 4'h0, 3'b001, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; fault = 3'd0;
    start1 = 1'b0; abort1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_fvld", fail_vld, 0);
    chk("rst_drive", {a, b, c, d}, 0);
    rst_n = 1'b1;
    $display("reset state checked");

    // Asynchronous reset mid-run with errors accumulated.
    fault = 3'd2;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (30) @(negedge clk);
    chk("pre_rst_err", err_cnt, 7);
    chk("pre_rst_drive", {a, b, c, d}, 7);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_drive", {a, b, c, d}, 0);
    chk("arst_err", err_cnt, 0);
    chk("arst_fvld", fail_vld, 0);
    chk("arst_fvec", fail_vec, 0);
    chk("arst_fmask", fail_mask, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", busy, 0);
    chk("post_rst_drive", {a, b, c, d}, 0);
    $display("async reset mid-run checked");

    for (int i = 0; i < 5; i++) begin
      fault = tbl[i].fault;
      sb.push_back(tbl[i]);
      run4(-1);
    end

    // start re-pulsed mid-run must not restart or shift completion.
    fault = 3'd0;
    sb.push_back(tbl[0]);
    run4(20);
    $display("mid-run start ignored");

    // Abort at cycle 10 of a failing run.
    fault = 3'd2;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_drive", {a, b, c, d}, 0);
    chk("abort_pass", pass, 0);
    chk("abort_err", err_cnt, 2);
    chk("abort_fvld", fail_vld, 1);
    chk("abort_fvec", fail_vec, 0);
    chk("abort_fmask", fail_mask, 3'b101);
    seen = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_done", seen, 0);
    $display("abort err_cnt=%0d busy=%0d", err_cnt, busy);

    // start and abort together in IDLE.
    fault = 3'd0;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    chk("sa_busy", busy, 0);
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("sa_busy2", busy, 0);
    chk("sa_drive", {a, b, c, d}, 0);
    $display("start+abort in idle checked");

    // start held high: back-to-back run after one IDLE cycle.
    start = 1'b1;
    @(negedge clk);
    repeat (64) @(negedge clk);
    chk("hold_done", done, 1);
    chk("hold_pass", pass, 1);
    @(negedge clk);
    chk("hold_idle_busy", busy, 0);
    chk("hold_idle_done", done, 0);
    @(negedge clk);
    chk("hold_restart_busy", busy, 1);
    chk("hold_restart_pass", pass, 0);
    start = 1'b0; abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("hold_abort_busy", busy, 0);
    $display("start held restart checked");

    // DWELL=1 golden run.
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      chk("d1_drive", {a1, b1, c1, d1}, k);
      chk("d1_done_early", done1, 0);
      @(negedge clk);
    end
    chk("d1_done", done1, 1);
    chk("d1_pass", pass1, 1);
    chk("d1_err", err_cnt1, 0);
    chk("d1_fvld", fail_vld1, 0);
    chk("d1_fmask", fail_mask1, 0);
    chk("d1_fvec", fail_vec1, 0);
    chk("d1_busy", busy1, 0);
    @(negedge clk);
    chk("d1_done_once", done1, 0);
    $display("dwell1 run pass=%0d", pass1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nand4_vector_sequencer.md
Name: nand4_vector_sequencer

Overview:
- Self-test controller for the 4-input NAND unit (inputs a,b,c,d; outputs e,f,g, three realizations of the same function).
- On a start request it walks all 16 input combinations in ascending order, 0000 to 1111, with a = MSB and d = LSB. It holds each combination for a programmable dwell, samples e/f/g on the last dwell cycle, and checks each against the expected value ~(a&b&c&d).
- It reports pass/fail, a failing-vector count, the first failing vector, and which output(s) failed.
- It sits between a test/top-level controller and the gate instance.

Parameters:
- DWELL, 4, clock cycles each vector is held; legal range 1..255; sampling happens on cycle DWELL-1 of the vector.
- CW, 8, dwell counter width; must satisfy 2^CW > DWELL.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a run; sampled each cycle; honoured only in IDLE.
- abort  input  1  terminate the run; has priority over start.
- a,b,c,d  output  1 each  registered drive to the gate under test.
- e,f,g  input  1 each  gate outputs; treated as combinational from a..d.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse when a run completes normally.
- pass  output  1  high after a completed run with zero failures; held until the next start.
- err_cnt  output  5  number of failing vectors in the current/last run (0..16).
- fail_vld  output  1  a failure has been captured this run.
- fail_vec  output  4  {a,b,c,d} of the first failing vector.
- fail_mask  output  3  sticky OR of per-output mismatches, bit0=e, bit1=f, bit2=g.

Behaviour:
- Reset (async, rst_n low): state=IDLE; a..d=0; busy, done, pass, fail_vld=0; err_cnt=0; fail_vec=0; fail_mask=0. Takes effect immediately mid-run. No resumption after release.
- States: IDLE, RUN, FIN.
- IDLE: a..d=0000. On start=1 and abort=0 at edge T0:
  - clear err_cnt, fail_vld, fail_vec, fail_mask and pass;
  - set vec=0 and dwell counter cnt=0;
  - go to RUN; busy=1 from T0.
- RUN:
  - {a,b,c,d}=vec (registered); cnt increments each cycle.
  - When cnt==DWELL-1, compare e/f/g against exp = ~&vec.
    - On any mismatch: err_cnt+=1; fail_mask|=mismatch bits; if fail_vld=0, set fail_vec=vec and fail_vld=1.
  - When cnt==DWELL-1 and vec!=15: vec+=1, cnt=0.
  - When cnt==DWELL-1 and vec==15: go to FIN (the comparison for vector 15 is included).
- FIN (one cycle):
  - done=1; busy=0; pass=(err_cnt==0), using the final count including vector 15; a..d=0000.
  - Next state IDLE.
  - pass is registered and remains valid from the FIN cycle onward.
- Latency: done is high on the cycle after edge T0+16*DWELL. With DWELL=4, 64 cycles of RUN.
- abort in RUN (or FIN): next edge goes to IDLE; a..d=0000; done stays 0; pass=0; err_cnt, fail_* hold their partial values.
- start while busy: ignored. start and abort in the same IDLE cycle: remain in IDLE.
- start held high: a new run begins on the first IDLE cycle after FIN.
- DWELL=1: every cycle samples; the vector advances every cycle.
- err_cnt cannot exceed 16, so it never wraps. vec never wraps because the run ends at 15.

Decomposition:
- Shared package: state encoding (IDLE/RUN/FIN), VEC_COUNT=16, LAST_VEC=4'hF, the mask bit indices for e/f/g, and the expected-value function nand4_exp(vec).
- Sub-module nand4_checker (combinational): inputs vec, e, f, g; outputs mismatch[2:0]. Reused by the other gate-unit benches.

Test Plan:
1. Reset behaviour: drive rst_n=0 at cycle 30 of a run -> busy, a..d, err_cnt and fail_* go to 0 before the next edge; after release the block stays in IDLE.
2. Golden gate, DWELL=4, start pulse:
   - a..d step 0000..1111, each held exactly 4 cycles;
   - done pulses once, one cycle after edge T0+64;
   - pass=1, err_cnt=0, fail_vld=0.
3. f stuck-at-1 -> err_cnt=1, fail_vec=4'hF, fail_mask=3'b010, pass=0, done pulses.
4. e inverted, g stuck-at-0 -> err_cnt=16, fail_vec=4'h0, fail_mask=3'b101, pass=0.
5. abort at cycle 10 of the run -> next cycle busy=0 and a..d=0000; done never pulses; pass=0.
6. Handshake corner cases:
   - start reasserted mid-run -> no restart; completion timing unchanged.
   - start and abort together in IDLE -> busy stays 0.
   - DWELL=1 golden run -> done one cycle after edge T0+16.
